// File: rtl/sequence_checker.sv
// Receive-side sequence checker: locks onto an incrementing data stream and then
// flags and counts every sample that departs from the freewheeling expected value.
module sequence_checker #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STEP         = 1,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     data,
    output logic                 locked,
    output logic                 mismatch,
    output logic [WIDTH-1:0]     expected,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked
    } state_e;

    state_e               state_q, state_d;
    logic [RunW-1:0]      run_cnt_q, run_cnt_d;
    logic [MissW-1:0]     miss_cnt_q, miss_cnt_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 mismatch_q, mismatch_d;
    logic [CNT_WIDTH-1:0] good_q, good_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;

    logic [RunW-1:0]      run_inc;
    logic [MissW-1:0]     miss_inc;
    logic                 in_seq;

    assign run_inc  = run_cnt_q + RunW'(1);
    assign miss_inc = miss_cnt_q + MissW'(1);
    assign in_seq   = (data == expected_q);

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        miss_cnt_d = miss_cnt_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
        good_d     = good_q;
        err_d      = err_q;

        if (enable) begin
            unique case (state_q)
                StSearch: begin
                    expected_d = data + StepW;
                    run_cnt_d  = RunW'(1);
                    state_d    = StAcquire;
                end
                StAcquire: begin
                    // A mismatch here simply reseeds the run from the new sample.
                    expected_d = data + StepW;
                    if (in_seq) begin
                        run_cnt_d = run_inc;
                        if (run_inc == RunW'(LOCK_COUNT)) begin
                            state_d    = StLocked;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        run_cnt_d = RunW'(1);
                    end
                end
                StLocked: begin
                    // Freewheel: never resync to the incoming data once locked.
                    expected_d = expected_q + StepW;
                    if (in_seq) begin
                        miss_cnt_d = '0;
                        if (good_q != '1) begin
                            good_d = good_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (err_q != '1) begin
                            err_d = err_q + CNT_WIDTH'(1);
                        end
                        if (miss_inc == MissW'(UNLOCK_COUNT)) begin
                            state_d = StSearch;
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StSearch;
            run_cnt_q  <= '0;
            miss_cnt_q <= '0;
            expected_q <= '0;
            mismatch_q <= 1'b0;
            good_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
            good_q     <= good_d;
            err_q      <= err_d;
        end
    end

    assign locked     = (state_q == StLocked);
    assign mismatch   = mismatch_q;
    assign expected   = expected_q;
    assign good_count = good_q;
    assign err_count  = err_q;

endmodule
